execution_muldiv: RTL

Next-generation EX stage. Keeps the existing datapath: destination mux, shamt/ra operand-A mux, immediate/rb operand-B mux, and alu_control + alu for single-cycle ops. Adds a registered EX/MEM output stage, an iterative multiply/divide unit with HI/LO registers, and a stall handshake to the hazard unit. All widths are parametrised.

---
 rtl/execution_muldiv.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execution_muldiv.sv
// EX stage: operand muxes, ALU, registered EX/MEM outputs and an iterative mul/div unit with HI/LO.
// Optional macro EXEC_FAST_MUL_EN: single-cycle combinational multiplier instead of shift-add.
module execution_muldiv #(
    parameter int NB_DATA         = 32,
    parameter int NB_REG_ADDRESS  = 5,
    parameter int NB_OP_FIELD     = 6,
    parameter int NB_ALU_OP_FIELD = 3,
    parameter logic [NB_ALU_OP_FIELD-1:0] ALU_OP_RTYPE = 3'b010
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_flush,
    input  logic                      i_shift_src,
    input  logic                      i_reg_dst,
    input  logic                      i_alu_src,
    input  logic [NB_ALU_OP_FIELD-1:0] i_alu_op,
    input  logic [NB_DATA-1:0]        i_ra_data,
    input  logic [NB_DATA-1:0]        i_rb_data,
    input  logic [NB_DATA-1:0]        i_sign_extender_data,
    input  logic [NB_REG_ADDRESS-1:0] i_rt_address,
    input  logic [NB_REG_ADDRESS-1:0] i_rd_address,
    output logic                      o_valid,
    output logic [NB_REG_ADDRESS-1:0] o_reg_address,
    output logic [NB_DATA-1:0]        o_mem_data,
    output logic [NB_DATA-1:0]        o_alu_data,
    output logic                      o_zero,
    output logic                      o_stall,
    output logic                      o_busy
);

    localparam int NB_SHAMT = $clog2(NB_DATA);
    localparam int NB_CNT   = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] ITER_LAST = NB_CNT'(NB_DATA - 1);

    localparam logic [NB_OP_FIELD-1:0] FN_MFHI  = NB_OP_FIELD'(6'h10);
    localparam logic [NB_OP_FIELD-1:0] FN_MTHI  = NB_OP_FIELD'(6'h11);
    localparam logic [NB_OP_FIELD-1:0] FN_MFLO  = NB_OP_FIELD'(6'h12);
    localparam logic [NB_OP_FIELD-1:0] FN_MTLO  = NB_OP_FIELD'(6'h13);
    localparam logic [NB_OP_FIELD-1:0] FN_MULT  = NB_OP_FIELD'(6'h18);
    localparam logic [NB_OP_FIELD-1:0] FN_MULTU = NB_OP_FIELD'(6'h19);
    localparam logic [NB_OP_FIELD-1:0] FN_DIV   = NB_OP_FIELD'(6'h1A);
    localparam logic [NB_OP_FIELD-1:0] FN_DIVU  = NB_OP_FIELD'(6'h1B);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_ctrl_t;

    state_t                    state, state_next;
    logic [NB_CNT-1:0]         iter_cnt;
    logic [NB_DATA-1:0]        work_hi, work_lo, operand;
    logic                      neg_q, neg_r, div_zero, div_op;
    logic [NB_DATA-1:0]        hi, lo;

    logic [NB_OP_FIELD-1:0]    funct;
    logic                      is_rtype, is_mult, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic                      accept, op_signed, sign_a, sign_b;
    logic [NB_DATA-1:0]        abs_a, abs_b, op_a, op_b, alu_result;
    logic [NB_SHAMT-1:0]       shamt;
    logic [NB_REG_ADDRESS-1:0] dst_address;
    alu_ctrl_t                 alu_ctrl;
    logic [NB_DATA:0]          mul_sum, div_shift, div_diff;
    logic [2*NB_DATA-1:0]      prod_raw, prod_fix;
    logic [NB_DATA-1:0]        quot_fix, rem_fix;

    assign funct    = i_sign_extender_data[NB_OP_FIELD-1:0];
    assign is_rtype = (i_alu_op == ALU_OP_RTYPE);
    assign is_mult  = is_rtype && (funct == FN_MULT || funct == FN_MULTU);
    assign is_div   = is_rtype && (funct == FN_DIV  || funct == FN_DIVU);
    assign is_mfhi  = is_rtype && (funct == FN_MFHI);
    assign is_mflo  = is_rtype && (funct == FN_MFLO);
    assign is_mthi  = is_rtype && (funct == FN_MTHI);
    assign is_mtlo  = is_rtype && (funct == FN_MTLO);
    assign accept   = i_valid && !i_flush && (state == ST_IDLE);

    assign o_stall = (state != ST_IDLE);
    assign o_busy  = o_stall;

    // MULT and DIV have an even funct code, their unsigned variants odd
    assign op_signed = ~funct[0];
    assign sign_a    = op_signed & i_ra_data[NB_DATA-1];
    assign sign_b    = op_signed & i_rb_data[NB_DATA-1];
    assign abs_a     = sign_a ? -i_ra_data : i_ra_data;
    assign abs_b     = sign_b ? -i_rb_data : i_rb_data;

    assign op_a = i_shift_src ? {{(NB_DATA-5){1'b0}}, i_sign_extender_data[10:6]} : i_ra_data;
    assign op_b = i_alu_src ? i_sign_extender_data : i_rb_data;
    assign shamt = op_a[NB_SHAMT-1:0];
    assign dst_address = i_reg_dst ? i_rd_address : i_rt_address;

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (is_rtype) begin
            case (funct)
                NB_OP_FIELD'(6'h00), NB_OP_FIELD'(6'h04): alu_ctrl = ALU_SLL;
                NB_OP_FIELD'(6'h02), NB_OP_FIELD'(6'h06): alu_ctrl = ALU_SRL;
                NB_OP_FIELD'(6'h03), NB_OP_FIELD'(6'h07): alu_ctrl = ALU_SRA;
                NB_OP_FIELD'(6'h20), NB_OP_FIELD'(6'h21): alu_ctrl = ALU_ADD;
                NB_OP_FIELD'(6'h22), NB_OP_FIELD'(6'h23): alu_ctrl = ALU_SUB;
                NB_OP_FIELD'(6'h24): alu_ctrl = ALU_AND;
                NB_OP_FIELD'(6'h25): alu_ctrl = ALU_OR;
                NB_OP_FIELD'(6'h26): alu_ctrl = ALU_XOR;
                NB_OP_FIELD'(6'h27): alu_ctrl = ALU_NOR;
                NB_OP_FIELD'(6'h2A): alu_ctrl = ALU_SLT;
                NB_OP_FIELD'(6'h2B): alu_ctrl = ALU_SLTU;
                default:             alu_ctrl = ALU_ADD;
            endcase
        end else begin
            case (i_alu_op)
                NB_ALU_OP_FIELD'(1): alu_ctrl = ALU_SUB;
                NB_ALU_OP_FIELD'(3): alu_ctrl = ALU_AND;
                NB_ALU_OP_FIELD'(4): alu_ctrl = ALU_OR;
                NB_ALU_OP_FIELD'(5): alu_ctrl = ALU_XOR;
                NB_ALU_OP_FIELD'(6): alu_ctrl = ALU_LUI;
                NB_ALU_OP_FIELD'(7): alu_ctrl = ALU_SLT;
                default:             alu_ctrl = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_NOR:  alu_result = ~(op_a | op_b);
            ALU_SLT:  alu_result = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result = {{(NB_DATA-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  alu_result = op_b << shamt;
            ALU_SRL:  alu_result = op_b >> shamt;
            ALU_SRA:  alu_result = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_result = op_b << (NB_DATA / 2);
            default:  alu_result = '0;
        endcase
    end

    // One shift-add / restoring-subtract step per cycle on {work_hi, work_lo}
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
    assign div_shift = {work_hi, work_lo[NB_DATA-1]};
    assign div_diff  = div_shift - {1'b0, operand};

    assign prod_raw = {work_hi, work_lo};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;
    assign quot_fix = div_zero ? '1 : (neg_q ? -work_lo : work_lo);
    assign rem_fix  = neg_r ? -work_hi : work_hi;

`ifdef EXEC_FAST_MUL_EN
    logic [2*NB_DATA-1:0] fast_prod;
    assign fast_prod = {{NB_DATA{1'b0}}, abs_a} * {{NB_DATA{1'b0}}, abs_b};
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_div) state_next = ST_DIV;
                else if (accept && is_mult) begin
`ifdef EXEC_FAST_MUL_EN
                    state_next = ST_DONE;
`else
                    state_next = ST_MUL;
`endif
                end
            end
            ST_MUL, ST_DIV: if (iter_cnt == '0) state_next = ST_DONE;
            ST_DONE:        state_next = ST_IDLE;
            default:        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            iter_cnt <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            operand  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_op   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (is_mult || is_div)) begin
                        iter_cnt <= ITER_LAST;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= is_div && (i_rb_data == '0);
                        div_op   <= is_div;
                        if (is_div) begin
                            work_hi <= '0;
                            work_lo <= abs_a;
                            operand <= abs_b;
                        end else begin
`ifdef EXEC_FAST_MUL_EN
                            {work_hi, work_lo} <= fast_prod;
                            operand            <= abs_a;
`else
                            work_hi <= '0;
                            work_lo <= abs_b;
                            operand <= abs_a;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    work_hi  <= mul_sum[NB_DATA:1];
                    work_lo  <= {mul_sum[0], work_lo[NB_DATA-1:1]};
                    iter_cnt <= iter_cnt - 1'b1;
                end
                ST_DIV: begin
                    if (!div_diff[NB_DATA]) begin
                        work_hi <= div_diff[NB_DATA-1:0];
                        work_lo <= {work_lo[NB_DATA-2:0], 1'b1};
                    end else begin
                        work_hi <= div_shift[NB_DATA-1:0];
                        work_lo <= {work_lo[NB_DATA-2:0], 1'b0};
                    end
                    iter_cnt <= iter_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
            if (div_op) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end else if (accept && is_mthi) begin
            hi <= i_ra_data;
        end else if (accept && is_mtlo) begin
            lo <= i_ra_data;
        end
    end

    // MT*/MUL/DIV retire with no register write; MF* goes through the reg_dst mux
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_valid       <= 1'b0;
            o_reg_address <= '0;
            o_mem_data    <= '0;
            o_alu_data    <= '0;
            o_zero        <= 1'b0;
        end else if (accept) begin
            o_valid    <= 1'b1;
            o_mem_data <= i_rb_data;
            if (is_mult || is_div || is_mthi || is_mtlo) begin
                o_reg_address <= '0;
                o_alu_data    <= '0;
                o_zero        <= 1'b0;
            end else if (is_mfhi || is_mflo) begin
                o_reg_address <= dst_address;
                o_alu_data    <= is_mfhi ? hi : lo;
                o_zero        <= 1'b0;
            end else begin
                o_reg_address <= dst_address;
                o_alu_data    <= alu_result;
                o_zero        <= (alu_result == '0);
            end
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule
